stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Multi-word stack access sequencer in the memory stage, directly upstream of the stack-pointer register block. It accepts PUSH/POP/CALL/RET/INT/RTI requests from the memory stage. It issues one data-memory access per cycle, driving the 2-bit SP operation (01 push, 10 pop) that the stack-pointer block consumes. It consumes the current SP value to form addresses, and reassembles popped words into PC/flag/register results while stalling the pipeline.

## Interface
Parameters:
- ADDR_W, 12, data-memory word-address width
- DATA_W, 16, memory word width
- STACK_TOP, 4095, SP reset value / highest stack address

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request strobe from memory stage
- req_op  in  3  stack_op_t: NOP=0 PUSH=1 POP=2 CALL=3 RET=4 INT=5 RTI=6, 7 reserved
- push_data  in  DATA_W  register value for PUSH
- pc_in  in  32  return PC for CALL/INT
- flags_in  in  3  flags for INT
- sp_value  in  32  current SP from stack-pointer block (points to next free slot)
- sp_op  out  2  to SP block: 00 hold, 01 push (decrement), 10 pop (increment)
- mem_addr  out  ADDR_W  data-memory address
- mem_wr / mem_rd  out  1  write / read strobe
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid cycle after mem_rd
- busy  out  1  pipeline stall
- done  out  1  one-cycle completion pulse
- pop_data  out  DATA_W  POP result
- pc_out  out  32  RET/RTI result
- flags_out  out  3  RTI result
- stack_fault  out  1  bounds violation pulse (see Configuration)

## Operation
- Word counts: PUSH/POP 1, CALL/RET 2, INT/RTI 3.
- Push order: CALL writes pc[31:16], then pc[15:0]. INT writes pc[31:16], pc[15:0], then {13'b0,flags}.
- Pop order is the reverse: RET reads pc_lo, then pc_hi. RTI reads flags, pc_lo, then pc_hi. POP reads one word.
- Push access: mem_addr = sp_value[ADDR_W-1:0], sp_op=01. Pop access: mem_addr = sp_value+1 (truncated), sp_op=10. The SP block updates at each edge, so consecutive words get consecutive addresses.
- FSM states: IDLE, WRITE (n write cycles), READ (n read cycles), DRAIN (capture last word), DONE.
  - IDLE→WRITE/READ on an accepted request.
  - WRITE→DONE after word n−1.
  - READ→DRAIN after word n−1.
  - DRAIN→DONE.
  - DONE→IDLE.
- A 2-bit word counter indexes the current word. Captured read words are assembled into pop_data, pc_out and flags_out. These hold their values until overwritten by the next pop-type op.
- Requests are accepted only in IDLE. req_valid while busy is ignored; upstream holds it because of stall. NOP and op 7 are ignored with no pulse.
- mem_addr and sp_op are decoded combinationally from registered state plus sp_value. All other outputs are registered.

## Timing
- Acceptance edge E0; cycles numbered after E0.
- Push-type op: accesses in cycles 1..n, done in cycle n+1.
- Pop-type op: reads in cycles 1..n, last data arrives in cycle n+1, results are valid and done pulses in cycle n+2.
- busy is high from cycle 1 through the done cycle inclusive. The next request can be accepted at the edge ending the done cycle.
- Reset (any time, including mid-sequence): state IDLE, counter 0, all outputs 0 (sp_op=00, mem_wr=mem_rd=0, busy=0, done=0, pop_data/pc_out/flags_out=0, stack_fault=0). No further accesses are issued; the SP block resets independently.

## Configuration
- STACK_BOUNDS_CHECK_EN defined:
  - At acceptance, a push-type op with sp_value < n−1 is a violation.
  - At acceptance, a pop-type op with sp_value > STACK_TOP−n is a violation.
  - On a violation: no memory access and sp_op stays 00. stack_fault pulses in cycle 1, busy is high for cycle 1 only, and done is not asserted.
- Undefined: stack_fault tied 0. Addresses wrap modulo 2^ADDR_W.

## Structure
- Package stack_pkg:
  - stack_op_t encoding
  - SP_OP_HOLD/PUSH/POP constants
  - word-count function
  - FSM state enum
- Sub-module stack_bounds_check: combinational fault decision, instantiated only under STACK_BOUNDS_CHECK_EN.

## Test plan
- Reset, sp=4095, PUSH 0xBEEF → cycle 1: mem_wr=1, addr 0xFFF, wdata 0xBEEF, sp_op=01; cycle 2: done=1; busy high cycles 1–2.
- sp=4093, CALL pc=0x12345678 → writes 0x1234@0xFFD, 0x5678@0xFFC with sp_op=01 in cycles 1–2; done in cycle 3.
- sp=4092, memory 0xFFD=0x5678, 0xFFE=0x1234, RET → reads 0xFFD, 0xFFE in cycles 1–2 with sp_op=10; cycle 4: done=1, pc_out=0x12345678.
- INT pc=0xA, flags=3'b101 at sp=4095, then RTI → pc_out=0x0000000A, flags_out=3'b101, final sp back to 4095.
- rst asserted in cycle 2 of INT → all outputs 0 immediately; no mem_wr after reset; next PUSH after release behaves normally.
- With STACK_BOUNDS_CHECK_EN, sp=4095, POP → stack_fault=1 in cycle 1, no mem_rd, sp_op=00, done never asserted.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types for the stack access sequencer: request opcodes, SP block
// operation codes, per-op word counts and the sequencer FSM states.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_INT  = 3'd5,
    OP_RTI  = 3'd6,
    OP_RSVD = 3'd7
  } stack_op_t;

  localparam logic [1:0] SP_OP_HOLD = 2'b00;
  localparam logic [1:0] SP_OP_PUSH = 2'b01;
  localparam logic [1:0] SP_OP_POP  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // Number of stack words moved by an op; zero marks ops that are ignored.
  function automatic logic [1:0] word_count(input stack_op_t op);
    case (op)
      OP_PUSH, OP_POP: return 2'd1;
      OP_CALL, OP_RET: return 2'd2;
      OP_INT,  OP_RTI: return 2'd3;
      default:         return 2'd0;
    endcase
  endfunction

  function automatic logic is_push_op(input stack_op_t op);
    return (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
  endfunction

  function automatic logic is_pop_op(input stack_op_t op);
    return (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
  endfunction

endpackage

// File: rtl/stack_bounds_check.sv
// Combinational stack bounds decision for a request about to be accepted.
// A push-type op must leave room for all of its words above address 0; a
// pop-type op must not read past STACK_TOP. Used only when the sequencer is
// built with STACK_BOUNDS_CHECK_EN.
module stack_bounds_check
  import stack_pkg::*;
#(
  parameter int STACK_TOP = 4095
) (
  input  stack_op_t   op,
  input  logic [31:0] sp_value,
  output logic        fault
);

  logic [31:0] n_words;

  // Compare the current SP against the span the op would touch.
  always_comb begin
    n_words = {30'd0, word_count(op)};
    fault   = 1'b0;
    if (is_push_op(op)) begin
      fault = (sp_value < (n_words - 32'd1));
    end else if (is_pop_op(op)) begin
      fault = (sp_value > (32'(STACK_TOP) - n_words));
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Multi-word stack access sequencer. Turns PUSH/POP/CALL/RET/INT/RTI into a
// run of single-word data-memory accesses, steering the SP block one step per
// access and reassembling popped words into pop_data / pc_out / flags_out.
// Optional build macro: STACK_BOUNDS_CHECK_EN enables the stack bounds check
// (faulting requests make no access and pulse stack_fault instead of done).
// Assumes DATA_W >= 16 so that a PC half fits in one memory word.
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int STACK_TOP = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] push_data,
  input  logic [31:0]       pc_in,
  input  logic [2:0]        flags_in,
  input  logic [31:0]       sp_value,
  output logic [1:0]        sp_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] pop_data,
  output logic [31:0]       pc_out,
  output logic [2:0]        flags_out,
  output logic              stack_fault
);

  state_t            state, state_nxt;
  logic [1:0]        cnt, cnt_nxt;
  stack_op_t         req_op_e;
  stack_op_t         op_q;
  logic [1:0]        n_q;
  logic              accept;
  logic              fault_chk;

  // Request payload captured at acceptance (data path, no reset needed).
  logic [31:0]       pc_q;
  logic [2:0]        flags_q;
  logic [DATA_W-1:0] push_q;

  // Source of the next write word: live inputs on the accept edge, the
  // captured payload afterwards.
  stack_op_t         src_op;
  logic [31:0]       src_pc;
  logic [2:0]        src_flags;
  logic [DATA_W-1:0] src_push;
  logic [DATA_W-1:0] wdata_nxt;

  // Read return tracking: read data lags mem_rd by one cycle.
  logic              rd_dly;
  logic [1:0]        rd_idx;

  logic [31:0]       sp_plus1;
  logic              unused_sp;

  assign req_op_e  = stack_op_t'(req_op);
  assign accept    = (state == ST_IDLE) && req_valid && (word_count(req_op_e) != 2'd0);
  assign sp_plus1  = sp_value + 32'd1;
  assign unused_sp = ^{sp_value[31:ADDR_W], sp_plus1[31:ADDR_W]};

`ifdef STACK_BOUNDS_CHECK_EN
  stack_bounds_check #(
    .STACK_TOP (STACK_TOP)
  ) u_bounds (
    .op       (req_op_e),
    .sp_value (sp_value),
    .fault    (fault_chk)
  );
`else
  assign fault_chk = 1'b0;
`endif

  // Word to write for a given op and word index (high PC half first).
  function automatic logic [DATA_W-1:0] write_word(
    input stack_op_t         op,
    input logic [1:0]        idx,
    input logic [31:0]       pc,
    input logic [2:0]        fl,
    input logic [DATA_W-1:0] pd
  );
    logic [DATA_W-1:0] w;
    w = '0;
    case (op)
      OP_PUSH: w = pd;
      OP_CALL, OP_INT: begin
        case (idx)
          2'd0:    w = DATA_W'(pc[31:16]);
          2'd1:    w = DATA_W'(pc[15:0]);
          default: w = DATA_W'(fl);
        endcase
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  // Next-state and word-counter decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          cnt_nxt = 2'd0;
          if (fault_chk) begin
            state_nxt = ST_FAULT;
          end else if (is_push_op(req_op_e)) begin
            state_nxt = ST_WRITE;
          end else begin
            state_nxt = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (cnt == (n_q - 2'd1)) begin
          state_nxt = ST_DONE;
          cnt_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      ST_READ: begin
        if (cnt == (n_q - 2'd1)) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = 2'd0;
        end else begin
          cnt_nxt = cnt + 2'd1;
        end
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      ST_FAULT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Select the payload feeding the registered write-data output.
  always_comb begin
    src_op    = op_q;
    src_pc    = pc_q;
    src_flags = flags_q;
    src_push  = push_q;
    if (state == ST_IDLE) begin
      src_op    = req_op_e;
      src_pc    = pc_in;
      src_flags = flags_in;
      src_push  = push_data;
    end
    wdata_nxt = '0;
    if (state_nxt == ST_WRITE) begin
      wdata_nxt = write_word(src_op, cnt_nxt, src_pc, src_flags, src_push);
    end
  end

  // Address and SP step follow the current state and the live SP value.
  always_comb begin
    sp_op    = SP_OP_HOLD;
    mem_addr = '0;
    case (state)
      ST_WRITE: begin
        sp_op    = SP_OP_PUSH;
        mem_addr = sp_value[ADDR_W-1:0];
      end
      ST_READ: begin
        sp_op    = SP_OP_POP;
        mem_addr = sp_plus1[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  // FSM state, counter and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 2'd0;
      op_q        <= OP_NOP;
      n_q         <= 2'd0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      stack_fault <= 1'b0;
      rd_dly      <= 1'b0;
      rd_idx      <= 2'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mem_wr      <= (state_nxt == ST_WRITE);
      mem_rd      <= (state_nxt == ST_READ);
      mem_wdata   <= wdata_nxt;
      busy        <= (state_nxt != ST_IDLE);
      done        <= (state_nxt == ST_DONE);
      stack_fault <= (state_nxt == ST_FAULT);
      rd_dly      <= mem_rd;
      rd_idx      <= cnt;
      if (accept) begin
        op_q <= req_op_e;
        n_q  <= word_count(req_op_e);
      end
    end
  end

  // Capture the request payload on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q    <= pc_in;
      flags_q <= flags_in;
      push_q  <= push_data;
    end
  end

  // Reassemble returning read words; results hold until the next pop-type op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_data  <= '0;
      pc_out    <= 32'd0;
      flags_out <= 3'd0;
    end else if (rd_dly) begin
      case (op_q)
        OP_POP: pop_data <= mem_rdata;
        OP_RET: begin
          if (rd_idx == 2'd0) pc_out[15:0]  <= mem_rdata[15:0];
          else                pc_out[31:16] <= mem_rdata[15:0];
        end
        OP_RTI: begin
          case (rd_idx)
            2'd0:    flags_out     <= mem_rdata[2:0];
            2'd1:    pc_out[15:0]  <= mem_rdata[15:0];
            default: pc_out[31:16] <= mem_rdata[15:0];
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: models the SP block and a word
// memory, runs a table of directed stack transactions with hand-computed
// per-cycle expectations, plus reset, ignored-op and bounds-fault sequences.
module tb_stack_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [15:0] push_data = 16'd0;
  logic [31:0] pc_in = 32'd0;
  logic [2:0]  flags_in = 3'd0;
  logic [31:0] sp;
  logic [1:0]  sp_op;
  logic [11:0] mem_addr;
  logic        mem_wr, mem_rd;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy, done, stack_fault;
  logic [15:0] pop_data;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;

  logic        sp_load = 1'b0;
  logic [31:0] sp_load_val = 32'd0;
  logic        ld_en = 1'b0;
  logic [11:0] ld_addr = 12'd0;
  logic [15:0] ld_data = 16'd0;
  logic [15:0] mem [0:4095];

  int n_chk  = 0;
  int n_fail = 0;

  stack_sequencer #(.ADDR_W(12), .DATA_W(16), .STACK_TOP(4095)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .push_data(push_data), .pc_in(pc_in), .flags_in(flags_in),
    .sp_value(sp), .sp_op(sp_op), .mem_addr(mem_addr), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pop_data(pop_data), .pc_out(pc_out),
    .flags_out(flags_out), .stack_fault(stack_fault)
  );

  always #5 clk = ~clk;

  // Stack-pointer block model (bench can load an arbitrary SP while idle).
  always @(posedge clk or posedge rst) begin
    if (rst)                 sp <= 32'd4095;
    else if (sp_load)        sp <= sp_load_val;
    else if (sp_op == 2'b01) sp <= sp - 32'd1;
    else if (sp_op == 2'b10) sp <= sp + 32'd1;
  end

  // Data memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (ld_en)  mem[ld_addr] <= ld_data;
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    string       nm;
    logic [2:0]  op;
    logic [31:0] sp0;
    logic [15:0] pd;
    logic [31:0] pc;
    logic [2:0]  fl;
    int          n;
    logic [11:0] a0, a1, a2;
    logic [15:0] w0, w1, w2;
    logic [31:0] sp_end;
    logic [15:0] e_pop;
    logic [31:0] e_pc;
    logic [2:0]  e_fl;
  } vec_t;

  vec_t vecs[10];
  int   nvec = 0;

  function automatic vec_t mk(string nm, logic [2:0] op, logic [31:0] sp0,
                              logic [15:0] pd, logic [31:0] pc, logic [2:0] fl, int n,
                              logic [11:0] a0, logic [11:0] a1, logic [11:0] a2,
                              logic [15:0] w0, logic [15:0] w1, logic [15:0] w2,
                              logic [31:0] sp_end, logic [15:0] e_pop,
                              logic [31:0] e_pc, logic [2:0] e_fl);
    vec_t v;
    v.nm = nm; v.op = op; v.sp0 = sp0; v.pd = pd; v.pc = pc; v.fl = fl; v.n = n;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.w0 = w0; v.w1 = w1; v.w2 = w2;
    v.sp_end = sp_end; v.e_pop = e_pop; v.e_pc = e_pc; v.e_fl = e_fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic        is_push;
    logic [11:0] ea;
    logic [15:0] ew;
    sp_load = 1'b1; sp_load_val = v.sp0;
    step();
    sp_load = 1'b0;
    req_valid = 1'b1; req_op = v.op; push_data = v.pd; pc_in = v.pc; flags_in = v.fl;
    step();
    req_valid = 1'b0; req_op = 3'd0;
    is_push = (v.op == 3'd1) || (v.op == 3'd3) || (v.op == 3'd5);
    for (int k = 0; k < v.n; k++) begin
      ea = (k == 0) ? v.a0 : (k == 1) ? v.a1 : v.a2;
      ew = (k == 0) ? v.w0 : (k == 1) ? v.w1 : v.w2;
      chk($sformatf("%s busy c%0d", v.nm, k + 1), 32'(busy), 32'd1);
      chk($sformatf("%s done c%0d", v.nm, k + 1), 32'(done), 32'd0);
      chk($sformatf("%s addr c%0d", v.nm, k + 1), 32'(mem_addr), 32'(ea));
      if (is_push) begin
        chk($sformatf("%s mem_wr c%0d", v.nm, k + 1), 32'(mem_wr), 32'd1);
        chk($sformatf("%s mem_rd c%0d", v.nm, k + 1), 32'(mem_rd), 32'd0);
        chk($sformatf("%s sp_op c%0d", v.nm, k + 1), 32'(sp_op), 32'd1);
        chk($sformatf("%s wdata c%0d", v.nm, k + 1), 32'(mem_wdata), 32'(ew));
      end else begin
        chk($sformatf("%s mem_rd c%0d", v.nm, k + 1), 32'(mem_rd), 32'd1);
        chk($sformatf("%s mem_wr c%0d", v.nm, k + 1), 32'(mem_wr), 32'd0);
        chk($sformatf("%s sp_op c%0d", v.nm, k + 1), 32'(sp_op), 32'd2);
      end
      step();
    end
    if (!is_push) begin
      chk($sformatf("%s drain busy", v.nm), 32'(busy), 32'd1);
      chk($sformatf("%s drain done", v.nm), 32'(done), 32'd0);
      chk($sformatf("%s drain mem_rd", v.nm), 32'(mem_rd), 32'd0);
      chk($sformatf("%s drain sp_op", v.nm), 32'(sp_op), 32'd0);
      step();
    end
    chk($sformatf("%s done pulse", v.nm), 32'(done), 32'd1);
    chk($sformatf("%s done busy", v.nm), 32'(busy), 32'd1);
    chk($sformatf("%s done mem_wr", v.nm), 32'(mem_wr), 32'd0);
    chk($sformatf("%s pop_data", v.nm), 32'(pop_data), 32'(v.e_pop));
    chk($sformatf("%s pc_out", v.nm), pc_out, v.e_pc);
    chk($sformatf("%s flags_out", v.nm), 32'(flags_out), 32'(v.e_fl));
    step();
    chk($sformatf("%s idle done", v.nm), 32'(done), 32'd0);
    chk($sformatf("%s idle busy", v.nm), 32'(busy), 32'd0);
    chk($sformatf("%s final sp", v.nm), sp, v.sp_end);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[nvec++] = mk("ret",   3'd4, 32'd4092, 16'h0, 32'h0, 3'd0, 2,
                      12'hFFD, 12'hFFE, 12'h0, 16'h0, 16'h0, 16'h0,
                      32'd4094, 16'h0000, 32'h12345678, 3'd0);
    vecs[nvec++] = mk("pop",   3'd2, 32'd4093, 16'h0, 32'h0, 3'd0, 1,
                      12'hFFE, 12'h0, 12'h0, 16'h0, 16'h0, 16'h0,
                      32'd4094, 16'h1234, 32'h12345678, 3'd0);
    vecs[nvec++] = mk("push",  3'd1, 32'd4095, 16'hBEEF, 32'h0, 3'd0, 1,
                      12'hFFF, 12'h0, 12'h0, 16'hBEEF, 16'h0, 16'h0,
                      32'd4094, 16'h1234, 32'h12345678, 3'd0);
    vecs[nvec++] = mk("call",  3'd3, 32'd4093, 16'h0, 32'h12345678, 3'd0, 2,
                      12'hFFD, 12'hFFC, 12'h0, 16'h1234, 16'h5678, 16'h0,
                      32'd4091, 16'h1234, 32'h12345678, 3'd0);
    vecs[nvec++] = mk("int",   3'd5, 32'd4095, 16'h0, 32'h0000000A, 3'b101, 3,
                      12'hFFF, 12'hFFE, 12'hFFD, 16'h0000, 16'h000A, 16'h0005,
                      32'd4092, 16'h1234, 32'h12345678, 3'd0);
    vecs[nvec++] = mk("rti",   3'd6, 32'd4092, 16'h0, 32'h0, 3'd0, 3,
                      12'hFFD, 12'hFFE, 12'hFFF, 16'h0, 16'h0, 16'h0,
                      32'd4095, 16'h1234, 32'h0000000A, 3'b101);
    vecs[nvec++] = mk("push0", 3'd1, 32'd0, 16'h0F0F, 32'h0, 3'd0, 1,
                      12'h000, 12'h0, 12'h0, 16'h0F0F, 16'h0, 16'h0,
                      32'hFFFFFFFF, 16'h1234, 32'h0000000A, 3'b101);
`ifndef STACK_BOUNDS_CHECK_EN
    vecs[nvec++] = mk("popwrap", 3'd2, 32'hFFFFFFFF, 16'h0, 32'h0, 3'd0, 1,
                      12'h000, 12'h0, 12'h0, 16'h0, 16'h0, 16'h0,
                      32'd0, 16'h0F0F, 32'h0000000A, 3'b101);
`endif

    // Reset state
    step(); step();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst sp_op", 32'(sp_op), 32'd0);
    chk("rst mem_wr", 32'(mem_wr), 32'd0);
    chk("rst mem_rd", 32'(mem_rd), 32'd0);
    chk("rst pc_out", pc_out, 32'd0);
    chk("rst stack_fault", 32'(stack_fault), 32'd0);
    rst = 1'b0;
    step();

    // Preload return frame for RET
    ld_en = 1'b1; ld_addr = 12'hFFD; ld_data = 16'h5678;
    step();
    ld_addr = 12'hFFE; ld_data = 16'h1234;
    step();
    ld_en = 1'b0;

    for (int i = 0; i < nvec; i++) run_vec(vecs[i]);

    // NOP and reserved op are ignored
    req_valid = 1'b1; req_op = 3'd0;
    step();
    req_op = 3'd7;
    chk("nop busy", 32'(busy), 32'd0);
    chk("nop sp_op", 32'(sp_op), 32'd0);
    step();
    req_valid = 1'b0; req_op = 3'd0;
    chk("op7 busy", 32'(busy), 32'd0);
    chk("op7 mem_wr", 32'(mem_wr), 32'd0);
    step();
    chk("op7 done", 32'(done), 32'd0);

`ifdef STACK_BOUNDS_CHECK_EN
    // POP at top of stack faults
    sp_load = 1'b1; sp_load_val = 32'd4095;
    step();
    sp_load = 1'b0; req_valid = 1'b1; req_op = 3'd2;
    step();
    req_valid = 1'b0; req_op = 3'd0;
    chk("flt stack_fault c1", 32'(stack_fault), 32'd1);
    chk("flt busy c1", 32'(busy), 32'd1);
    chk("flt mem_rd c1", 32'(mem_rd), 32'd0);
    chk("flt sp_op c1", 32'(sp_op), 32'd0);
    step();
    chk("flt stack_fault c2", 32'(stack_fault), 32'd0);
    chk("flt busy c2", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("flt no done c%0d", k + 2), 32'(done), 32'd0);
      step();
    end
    chk("flt sp unchanged", sp, 32'd4095);
    // INT needing three slots at sp=1 faults
    sp_load = 1'b1; sp_load_val = 32'd1;
    step();
    sp_load = 1'b0; req_valid = 1'b1; req_op = 3'd5;
    step();
    req_valid = 1'b0; req_op = 3'd0;
    chk("flt int stack_fault", 32'(stack_fault), 32'd1);
    chk("flt int mem_wr", 32'(mem_wr), 32'd0);
    step(); step();
`else
    chk("no-check stack_fault", 32'(stack_fault), 32'd0);
`endif

    // Reset in cycle 2 of INT
    sp_load = 1'b1; sp_load_val = 32'd4095;
    step();
    sp_load = 1'b0; req_valid = 1'b1; req_op = 3'd5; pc_in = 32'h0000000A; flags_in = 3'b101;
    step();
    req_valid = 1'b0; req_op = 3'd0;
    chk("mid c1 mem_wr", 32'(mem_wr), 32'd1);
    step();
    chk("mid c2 addr", 32'(mem_addr), 32'hFFE);
    rst = 1'b1;
    #1;
    chk("mid rst mem_wr", 32'(mem_wr), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst sp_op", 32'(sp_op), 32'd0);
    chk("mid rst addr", 32'(mem_addr), 32'd0);
    chk("mid rst pc_out", pc_out, 32'd0);
    chk("mid rst flags_out", 32'(flags_out), 32'd0);
    chk("mid rst pop_data", 32'(pop_data), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("mid hold mem_wr %0d", k), 32'(mem_wr), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("mid after mem_wr %0d", k), 32'(mem_wr), 32'd0);
      chk($sformatf("mid after busy %0d", k), 32'(busy), 32'd0);
    end
    run_vec(mk("push_after_rst", 3'd1, 32'd4095, 16'h1357, 32'h0, 3'd0, 1,
               12'hFFF, 12'h0, 12'h0, 16'h1357, 16'h0, 16'h0,
               32'd4094, 16'h0000, 32'h00000000, 3'd0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
